// File: rtl/inst_fetch_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO that decouples fetch from decode and drops everything on flush/branch cancel.
// Optional zero-latency pass-through when empty is enabled by defining FQ_BYPASS_EN.
module inst_fetch_queue #(
  parameter int BUS_W = 69,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       br_cancel,
  input  logic                       fs_to_fq_valid,
  input  logic [BUS_W-1:0]           fs_to_fq_bus,
  output logic                       fq_allow_in,
  output logic                       fq_to_ds_valid,
  output logic [BUS_W-1:0]           fq_to_ds_bus,
  input  logic                       ds_allow_in,
  output logic [$clog2(DEPTH+1)-1:0] fq_count,
  output logic                       fq_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [BUS_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic kill;
  logic bypass_take;
  logic enq;
  logic deq;

  always_comb begin
    kill           = flush | br_cancel;
    fq_allow_in    = (count_q != CNT_W'(DEPTH));
    fq_empty       = (count_q == '0);
    fq_count       = count_q;
`ifdef FQ_BYPASS_EN
    // Empty queue forwards the incoming bundle combinationally; a bundle
    // consumed this way is never written into storage.
    fq_to_ds_valid = ~fq_empty | (fs_to_fq_valid & ~kill);
    fq_to_ds_bus   = fq_empty ? fs_to_fq_bus : mem_q[rd_ptr_q];
    bypass_take    = fq_empty & fs_to_fq_valid & ~kill & ds_allow_in;
`else
    fq_to_ds_valid = ~fq_empty;
    fq_to_ds_bus   = mem_q[rd_ptr_q];
    bypass_take    = 1'b0;
`endif
    enq = fs_to_fq_valid & fq_allow_in & ~kill & ~bypass_take;
    deq = fq_to_ds_valid & ds_allow_in & ~kill & ~bypass_take;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (kill) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= fs_to_fq_bus;
  end

endmodule
